full_adder_n: RTL and testbench
===============================

// Module: full_adder_n
// PURPOSE
// - Registered N-bit two's-complement/unsigned adder for the RISC-V datapath (ALU add, PC/address add).
// - Combinational ripple-carry chain of 1-bit full-adder cells; sum and overflow captured in output flops.
// - One clock, one result per cycle, fixed 1-cycle latency, no handshake.
// PARAMETERS
// - N  default 64  operand/result width in bits (N >= 2)
// PORTS
// - clk       in   1  clock; all state updates on rising edge
// - reset     in   1  asynchronous, active-high reset
// - a         in   N  first addend
// - b         in   N  second addend
// - sum       out  N  registered (a + b) mod 2^N
// - overflow  out  1  registered unsigned carry-out of bit N-1
// - ovf_signed out 1  registered signed overflow; present only with FULL_ADDER_SIGNED_OVF_EN
// BEHAVIOUR
// - Interface: one clock (clk); reset is asynchronous and active-high (reset).
// - Reset: while reset=1, sum=0, overflow=0 (and ovf_signed=0) immediately, independent of clk.
// - Datapath: bit cell i: s[i]=a[i]^b[i]^c[i]; c[i+1]=(a[i]&b[i])|(c[i]&(a[i]^b[i])); c[0]=0.
// - Cells instantiated via generate loop over 0..N-1; no behavioural '+' on the full width.
// - Edge k: sum<=s[N-1:0], overflow<=c[N]; operands sampled at edge k visible after edge k.
// - Latency exactly 1 cycle; throughput 1 op/cycle; back-to-back operands allowed every cycle.
// - Wrap-around: result truncated to N bits; carry reported only through overflow.
// - overflow is the unsigned carry, not signed overflow: 0x7FFF..F + 0x8000..0 -> overflow=0.
// - Reset deasserted between edges: first capture at next rising edge after deassertion.
// - Reset asserted mid-stream: in-flight result discarded, outputs 0 until first edge after release.
// - No X propagation from reset state: outputs defined from time of first reset assertion.
// CONFIGURATION
// - Macro FULL_ADDER_SIGNED_OVF_EN.
// - Defined: port ovf_signed present; ovf_signed<=c[N]^c[N-1] on each edge; reset value 0.
// - Not defined: port ovf_signed and its flop absent; all other behaviour identical.
// TESTING
// - N=64, reset pulse -> sum=0, overflow=0 during reset without any clk edge.
// - a=2, b=5 -> one cycle later sum=7, overflow=0.
// - a=0xF43A_A301, b=0xB9C2_D427 -> sum=0x0000_0001_ADFD_7728, overflow=0.
// - a=0, b=0xFFFF -> sum=0xFFFF, overflow=0; then a=0x7FFF_FFFF_FFFF_FFFF, b=0x8FFF_FFFF_FFFF_0000
//   -> sum=0x0FFF_FFFF_FFFE_FFFF, overflow=1, ovf_signed=0 (macro on).
// - a=b=0xFFFF_FFFF_FFFF_FFFF -> sum=0xFFFF_FFFF_FFFF_FFFE, overflow=1, ovf_signed=0;
//   a=b=0x4000_0000_0000_0000 -> sum=0x8000_0000_0000_0000, overflow=0, ovf_signed=1.
// - Stream 3 operand pairs on consecutive edges, assert reset after 2nd -> outputs 0 at once,
//   3rd result never appears; after release next pair appears 1 cycle later.

Source files
------------

// File: rtl/full_adder_n_if.sv
// full_adder_n_if: operand/result bundle for full_adder_n; ovf_signed exists only with FULL_ADDER_SIGNED_OVF_EN
interface full_adder_n_if #(parameter int N = 64);
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic [N-1:0] sum;
   logic         overflow;
`ifdef FULL_ADDER_SIGNED_OVF_EN
   logic         ovf_signed;
   modport master (output a, b, input sum, overflow, ovf_signed);
   modport slave  (input a, b, output sum, overflow, ovf_signed);
`else
   modport master (output a, b, input sum, overflow);
   modport slave  (input a, b, output sum, overflow);
`endif
endinterface

// File: rtl/full_adder_n.sv
// full_adder_n: registered N-bit ripple-carry adder, 1-cycle latency; FULL_ADDER_SIGNED_OVF_EN adds ovf_signed
module full_adder_n #(parameter int N = 64) (
   input logic          clk,
   input logic          reset,
   full_adder_n_if.slave bus
);
   logic [N:0]   w_c;
   logic [N-1:0] w_s;
   logic [N-1:0] r_sum;
   logic         r_ovf;
   assign w_c[0] = 1'b0;
   for (genvar i = 0; i < N; i++) begin : g_cell
      assign w_s[i]   = bus.a[i] ^ bus.b[i] ^ w_c[i];
      assign w_c[i+1] = (bus.a[i] & bus.b[i]) | (w_c[i] & (bus.a[i] ^ bus.b[i]));
   end
`ifdef FULL_ADDER_SIGNED_OVF_EN
   logic r_ovf_s;
   // signed overflow: carry into and out of the sign bit disagree
   always_ff @(posedge clk or posedge reset)
      if (reset) r_ovf_s <= 1'b0;
      else       r_ovf_s <= w_c[N] ^ w_c[N-1];
   assign bus.ovf_signed = r_ovf_s;
`endif
   // capture the truncated sum and the unsigned carry-out
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         r_sum <= '0;
         r_ovf <= 1'b0;
      end else begin
         r_sum <= w_s;
         r_ovf <= w_c[N];
      end
   assign bus.sum      = r_sum;
   assign bus.overflow = r_ovf;
endmodule

// File: tb/tb_full_adder_n.sv
// tb_full_adder_n: directed vectors plus reset corner sequences for full_adder_n
module tb_full_adder_n;
   logic clk = 1'b0;
   logic reset = 1'b0;
   int   total = 0;
   int   bad = 0;
   full_adder_n_if #(.N(64)) bus ();
   full_adder_n #(.N(64)) dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;
   typedef struct {
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] s;
      logic        o;
      logic        so;
   } vec_t;
   vec_t v[10];
   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask
   task automatic chk_out(input string nm, input logic [63:0] s, input logic o, input logic so);
      chk({nm, ".sum"}, bus.sum, s);
      chk({nm, ".overflow"}, {63'd0, bus.overflow}, {63'd0, o});
`ifdef FULL_ADDER_SIGNED_OVF_EN
      chk({nm, ".ovf_signed"}, {63'd0, bus.ovf_signed}, {63'd0, so});
`else
      if (so === 1'bx) total++;
`endif
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   initial begin
      v[0] = '{64'd2, 64'd5, 64'd7, 1'b0, 1'b0};
      v[1] = '{64'hF43A_A301, 64'hB9C2_D427, 64'h0000_0001_ADFD_7728, 1'b0, 1'b0};
      v[2] = '{64'd0, 64'hFFFF, 64'hFFFF, 1'b0, 1'b0};
      v[3] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h8FFF_FFFF_FFFF_0000, 64'h0FFF_FFFF_FFFE_FFFF, 1'b1, 1'b0};
      v[4] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0};
      v[5] = '{64'h4000_0000_0000_0000, 64'h4000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
      v[6] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};
      v[7] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
      v[8] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'd0, 1'b1, 1'b1};
      v[9] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b1, 1'b0};
      bus.a = 64'h1234;
      bus.b = 64'h5678;
      #1 reset = 1'b1;
      #2 chk_out("reset_no_clk", 64'd0, 1'b0, 1'b0);
      tick();
      chk_out("reset_held", 64'd0, 1'b0, 1'b0);
      #2 reset = 1'b0;
      #1 chk_out("after_release", 64'd0, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         bus.a = v[i].a;
         bus.b = v[i].b;
         tick();
         chk_out($sformatf("vec%0d", i), v[i].s, v[i].o, v[i].so);
      end
      bus.a = 64'd10; bus.b = 64'd20;
      tick();
      chk_out("stream1", 64'd30, 1'b0, 1'b0);
      bus.a = 64'hFFFF_FFFF_FFFF_FFF0; bus.b = 64'h20;
      tick();
      chk_out("stream2", 64'h10, 1'b1, 1'b0);
      bus.a = 64'd100; bus.b = 64'd200;
      #2 reset = 1'b1;
      #1 chk_out("midstream_reset", 64'd0, 1'b0, 1'b0);
      tick();
      chk_out("third_discarded", 64'd0, 1'b0, 1'b0);
      #2 reset = 1'b0;
      bus.a = 64'd40; bus.b = 64'd2;
      #1 chk_out("released_no_edge", 64'd0, 1'b0, 1'b0);
      tick();
      chk_out("post_reset_pair", 64'd42, 1'b0, 1'b0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
